antirrebote: RTL

Debounces and synchronizes one raw, asynchronous pushbutton or switch input. Produces a clean, glitch-free level on the `clk` domain. Sits directly upstream of `detector_flanco`: `senal_limpia` drives that block's `senal_entrada`, so each physical press yields exactly one `flanco_positovo` pulse. A synchronizer chain is followed by a 4-state FSM that requires a configurable run of identical samples before the output level changes.

---
 rtl/antirrebote_pkg.sv | 18 +
 rtl/antirrebote_sincronizador.sv | 44 ++++
 rtl/antirrebote.sv | 119 +++++++++++
 3 files changed

// File: rtl/antirrebote_pkg.sv
// antirrebote_pkg
// Shared types and default parameters for the pushbutton debouncer.
//   estado_t             : debouncer FSM state encoding
//   N_SYNC_DEF           : default synchronizer depth
//   DEBOUNCE_CYCLES_DEF  : default qualification length (10 ms at 100 MHz)
package antirrebote_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } estado_t;

   localparam int N_SYNC_DEF          = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/antirrebote_sincronizador.sv
// sincronizador
// Multi-flop synchronizer for one asynchronous level input. Reusable for
// any board input that must be brought into the clk domain.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset, clears every stage to 0
//   d   : asynchronous input level
//   q   : synchronized level (last stage)
module sincronizador
   import antirrebote_pkg::*;
#(
   parameter int N_SYNC = N_SYNC_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [N_SYNC-1:0] sync_reg;

   // Stage 0 captures the raw input; every later stage only resolves
   // metastability of the stage before it.
   generate
      for (genvar gi = 0; gi < N_SYNC; gi++) begin : g_stage
         logic stage_in;
         if (gi == 0) begin : g_first
            assign stage_in = d;
         end else begin : g_next
            assign stage_in = sync_reg[gi-1];
         end

         always_ff @(posedge clk) begin
            if (!rst) begin
               sync_reg[gi] <= 1'b0;
            end else begin
               sync_reg[gi] <= stage_in;
            end
         end
      end
   endgenerate

   assign q = sync_reg[N_SYNC-1];

endmodule

// File: rtl/antirrebote.sv
// antirrebote
// Debounces and synchronizes one raw pushbutton/switch input. A new level is
// accepted only after DEBOUNCE_CYCLES consecutive equal synchronized samples;
// any disagreeing sample restarts qualification from zero.
//   clk           : system clock, rising edge
//   rst           : synchronous active-low reset
//   senal_entrada : raw asynchronous input level
//   senal_limpia  : debounced, registered level (feeds detector_flanco)
//   ocupado       : high while a candidate level change is being qualified
module antirrebote
   import antirrebote_pkg::*;
#(
   parameter int N_SYNC          = N_SYNC_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic senal_entrada,
   output logic senal_limpia,
   output logic ocupado
);

   generate
      if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
         $fatal(1, "antirrebote: DEBOUNCE_CYCLES must be 2 or more");
      end
      if (N_SYNC < 2) begin : g_bad_sync
         $fatal(1, "antirrebote: N_SYNC must be 2 or more");
      end
   endgenerate

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   // The counter never goes past DEBOUNCE_CYCLES-1, which always fits in
   // CNT_W bits, so it cannot wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s;
   estado_t          estado_reg, estado_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             limpia_reg, limpia_next;

   sincronizador #(
      .N_SYNC (N_SYNC)
   ) u_sincronizador (
      .clk (clk),
      .rst (rst),
      .d   (senal_entrada),
      .q   (s)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         estado_reg <= IDLE_LOW;
         cnt_reg    <= '0;
         limpia_reg <= 1'b0;
      end else begin
         estado_reg <= estado_next;
         cnt_reg    <= cnt_next;
         limpia_reg <= limpia_next;
      end
   end

   // In the WAIT states the sample check comes before the terminal count:
   // a disagreeing sample on the last counted edge is a revert, not an accept.
   always_comb begin
      estado_next = estado_reg;
      cnt_next    = cnt_reg;
      limpia_next = limpia_reg;
      case (estado_reg)
         IDLE_LOW: begin
            if (s) begin
               estado_next = WAIT_HIGH;
               cnt_next    = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!s) begin
               estado_next = IDLE_LOW;
               cnt_next    = '0;
            end else if (cnt_reg == CNT_LAST) begin
               estado_next = IDLE_HIGH;
               limpia_next = 1'b1;
               cnt_next    = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!s) begin
               estado_next = WAIT_LOW;
               cnt_next    = CNT_ONE;
            end
         end
         WAIT_LOW: begin
            if (s) begin
               estado_next = IDLE_HIGH;
               cnt_next    = '0;
            end else if (cnt_reg == CNT_LAST) begin
               estado_next = IDLE_LOW;
               limpia_next = 1'b0;
               cnt_next    = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            estado_next = IDLE_LOW;
            cnt_next    = '0;
            limpia_next = 1'b0;
         end
      endcase
   end

   assign senal_limpia = limpia_reg;
   // Decoded from the state register alone, so it cannot glitch.
   assign ocupado = (estado_reg == WAIT_HIGH) || (estado_reg == WAIT_LOW);

endmodule
